muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle shift-add multiply sequencer for the pipelined core's execute stage.
//  Handles MUL, UMULL and SMULL (Long/Unsigned control bits).
//  Accepts a start pulse from the execute stage and holds the pipeline with StallReq
//  while iterating. Presents a 64-bit product for one Done cycle.
//  Sits beside the ALU; the hazard unit ORs StallReq into StallF/StallD/StallE.
// PARAMETERS
//  WIDTH    32   operand width; product is 2*WIDTH bits
//  CNTW     6    iteration counter width, >= clog2(WIDTH)+1
// PORTS
//  clk        in   1       clock; all state changes on the rising edge
//  reset      in   1       synchronous, active-high; one clock; sync reset only
//  StartE     in   1       execute stage holds a multiply with CondExE=1 (level, sampled in IDLE)
//  UnsignedE  in   1       1 = unsigned operands, 0 = two's-complement signed
//  LongE      in   1       1 = 64-bit result required; 0 = low word only (Hi still computed)
//  AbortE     in   1       FlushE from the hazard unit; cancels the operation in flight
//  SrcAE      in   WIDTH   multiplicand
//  SrcBE      in   WIDTH   multiplier
//  StallReq   out  1       hold F/D/E registers
//  Busy       out  1       sequencer is not IDLE
//  Done       out  1       one-cycle pulse; ResultHi/ResultLo valid
//  ResultLo   out  WIDTH   product bits [WIDTH-1:0]
//  ResultHi   out  WIDTH   product bits [2*WIDTH-1:WIDTH]; forced 0 when LongE latched 0
// BEHAVIOUR
//  Reset: state=IDLE. Counter, accumulators and ResultHi/ResultLo are 0.
//   StallReq=0, Busy=0, Done=0. Reset overrides every other input, including mid-RUN.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - StallReq = StartE (combinational, same cycle).
//   - On StartE & ~AbortE: latch Unsigned/Long.
//   - Signed mode: latch |SrcAE| and |SrcBE|; sign = SrcAE[W-1]^SrcBE[W-1].
//     |0x80000000| = 0x80000000 (unsigned magnitude).
//   - Clear the 2*WIDTH accumulator, set counter=WIDTH, go to RUN.
//  RUN, each cycle:
//   - If multiplier LSB=1, add multiplicand to accumulator upper half (WIDTH+1-bit sum, carry kept).
//   - Shift accumulator/multiplier right by 1 and decrement the counter.
//   - When the counter reaches 0, go to DONE.
//   - StallReq=1 and Busy=1 throughout.
//  DONE:
//   - Apply 64-bit two's-complement negate if sign=1 (signed mode only) and register into ResultHi/ResultLo.
//   - Done=1 and StallReq=0 so the E stage advances while capturing the result. Busy=1.
//   - Return to IDLE next cycle.
//  Latency: StartE sampled at edge 0 -> Done high during cycle WIDTH+1 -> IDLE at WIDTH+2.
//  ResultHi/ResultLo hold their value until the next DONE. They are not cleared on a new start.
//  AbortE:
//   - In RUN or DONE: return to IDLE next edge; no Done pulse; results unchanged. Abort beats completion.
//   - In IDLE: suppresses the start.
//  StartE while Busy: ignored; no queueing.
//  Back-to-back operations: a StartE seen in the IDLE cycle after DONE starts a new operation.
//  Zero operands still take the full WIDTH iterations (fixed latency, no early exit).
// TESTING
//  1 unsigned 7*6, LongE=1 -> StallReq high 33 cycles, Done at cycle 33, Hi=0, Lo=0x0000002A.
//  2 signed -3*5 (0xFFFFFFFD, 0x5) -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
//  3 unsigned 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
//    Same operands signed -> Hi=0, Lo=1.
//  4 signed 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0. LongE=0 -> Hi=0.
//  5 AbortE at RUN cycle 10 -> Busy/StallReq low next cycle, no Done, results keep prior value.
//    StartE pulsed mid-RUN -> ignored.
//  6 reset at RUN cycle 5 -> all outputs 0 next cycle.
//    A fresh start afterwards completes correctly with full latency.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle shift-add multiplier for MUL/UMULL/SMULL in the execute stage.
// Signed operands are multiplied as magnitudes; the sign is applied in DONE.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             UnsignedE,
    input  logic             LongE,
    input  logic             AbortE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             StallReq,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic               long_q, long_d;
    logic [WIDTH-1:0]   reshi_q, reshi_d;
    logic [WIDTH-1:0]   reslo_q, reslo_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    // Negating the most negative value wraps back to itself, which is its correct unsigned magnitude.
    assign a_mag = (!UnsignedE && SrcAE[WIDTH-1]) ? (~SrcAE + 1'b1) : SrcAE;
    assign b_mag = (!UnsignedE && SrcBE[WIDTH-1]) ? (~SrcBE + 1'b1) : SrcBE;
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    assign prod  = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        long_d   = long_q;
        reshi_d  = reshi_q;
        reslo_d  = reslo_q;
        StallReq = 1'b0;
        Done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                StallReq = StartE;
                if (StartE && !AbortE) begin
                    long_d   = LongE;
                    neg_d    = !UnsignedE && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = CNTW'(WIDTH);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                StallReq = 1'b1;
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) state_d = S_DONE;
                if (AbortE)            state_d = S_IDLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!AbortE) begin
                    Done    = 1'b1;
                    reshi_d = long_q ? prod[2*WIDTH-1:WIDTH] : '0;
                    reslo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            StallReq = 1'b0;
            Done     = 1'b0;
        end
    end

    // During the Done cycle the product is forwarded so E captures it while it is registered.
    assign ResultLo = Done ? reslo_d : reslo_q;
    assign ResultHi = Done ? reshi_d : reshi_q;
    assign Busy     = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            long_q   <= 1'b0;
            reshi_q  <= '0;
            reslo_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            long_q   <= long_d;
            reshi_q  <= reshi_d;
            reslo_q  <= reslo_d;
        end
    end

endmodule
